ddc_daq_accum_serializer: RTL and testbench
===========================================

// Module: ddc_daq_accum_serializer
// PURPOSE
//  Parametrised decimating integrate-and-dump stage for the DDC DAQ chain: N_CH complex lanes.
//  Each lane is accumulated over a runtime-set number of valid samples. Dumped sums are
//  snapshotted, then serialised one channel per cycle with a channel index and frame marker.
//  Generalises the fixed 4-lane/96-bit output path: channel count, widths and decimation are
//  parametrised, with overrun detection and a frame counter.
// PARAMETERS
//  N_CH   4   number of complex lanes (>=1)
//  IN_W   16  width of each I and Q input sample, two's complement
//  ACC_W  48  width of each I and Q accumulator/output; exact when ACC_W >= IN_W+CNT_W
//  CNT_W  16  width of decim_len and of the sample counter
//  CH_W   localparam = max(1, $clog2(N_CH))
// PORTS
//  dev_clk         in   1            sole clock
//  dev_rst         in   1            synchronous, active-high reset
//  data_in         in   N_CH*2*IN_W  lane k at [k*2*IN_W +: 2*IN_W]; I upper half, Q lower half
//  valid_in        in   1            data_in qualifier; gaps allowed
//  resync          in   1            restart integration; latch decim_len
//  decim_len       in   CNT_W        samples per dump; 0 is treated as 1
//  data_out        out  2*ACC_W      {I_sum, Q_sum} of channel ch_out
//  ch_out          out  CH_W         channel index of data_out
//  sof_out         out  1            high with channel 0 of each frame
//  valid_out       out  1            data_out/ch_out/sof_out qualifier; no backpressure
//  overrun         out  1            sticky: dump arrived while serialiser busy
//  frame_cnt       out  32           accepted frames since last resync; wraps
// BEHAVIOUR
//  Reset: every output is 0. Accumulators and counters are 0. Accumulator FSM = WAIT_SYNC; serialiser = IDLE.
//  Accumulator FSM:
//   - WAIT_SYNC: valid_in is ignored. resync -> RUN.
//   - RUN stays in RUN; resync re-enters RUN with cleared state.
//  resync (any state, priority over valid_in in the same cycle):
//   - clears accumulators, sample count, overrun and frame_cnt
//   - L_reg <= max(decim_len,1)
//   - serialiser -> IDLE, so valid_out = 0 next cycle
//   - sample presented in the resync cycle is discarded
//  RUN, valid_in=1, cnt < L_reg-1: acc_k += sext(I_k), sext(Q_k); cnt++.
//  RUN, valid_in=1, cnt == L_reg-1 (dump):
//   - acc_k+sample_k goes to the hold bank; acc_k <= 0; cnt <= 0; L_reg <= max(decim_len,1)
//   - serialiser IDLE: serialiser -> SHIFT (idx=0); frame_cnt++
//   - serialiser SHIFT (busy): hold bank not overwritten; frame dropped; overrun <= 1; frame_cnt unchanged
//  Serialiser SHIFT:
//   - each cycle: valid_out=1, ch_out=idx, data_out=hold[idx], sof_out=(idx==0), idx++
//   - after idx==N_CH-1 -> IDLE
//   - a dump in the final SHIFT cycle (idx==N_CH-1) is an overrun
//   - back-to-back frames need L_reg >= N_CH at full valid_in rate
//  Latency: channel 0 appears the cycle after the dump cycle; channel k appears k cycles later.
//  Arithmetic: sign-extend to ACC_W; two's-complement wrap on overflow; no saturation.
//  valid_in=0: no accumulate, no count. Outputs are registered; IDLE drives valid_out=0 and sof_out=0; data_out and ch_out hold their last values.
//  Reset mid-frame discards everything; the block re-waits for resync.
// TESTING
//  1. N_CH=4, decim_len=8, resync; 8 valid samples with I_k=k+1, Q_k=-(k+1)
//     -> 4 consecutive valid_out beats: ch 0..3, I=8(k+1), Q=-8(k+1), sof on ch0 only, frame_cnt=1.
//  2. valid_in pulses after reset, before any resync -> valid_out stays 0; the first frame after resync is unaffected.
//  3. decim_len=2, N_CH=4, continuous valid
//     -> second dump during SHIFT: overrun=1, frame dropped, frame_cnt=1; resync clears overrun and frame_cnt.
//  4. decim_len=8: resync after 5 samples, then 8 samples of value 1
//     -> first output I=Q=8; the pre-resync partial sum is absent.
//  5. N_CH=1, I=-32768, Q=32767, decim_len=65535 -> I=-2147450880, Q=2147385345 exact.
//     decim_len=0 -> dump on every sample, no overrun.
//  6. Case 1 stimulus with valid_in high every 3rd cycle -> identical sums.
//     Beats start 1 cycle after the 8th valid sample.

Source files
------------

// File: rtl/ddc_daq_accum_serializer.sv
// Decimating integrate-and-dump over N_CH complex lanes. Each dumped frame is snapshotted
// into a per-lane hold bank and serialised one channel per cycle with a frame marker.

module ddc_daq_accum_lane #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               acc_en,
    input  logic               dump,
    input  logic               load_hold,
    input  logic [2*IN_W-1:0]  sample,
    output logic [2*ACC_W-1:0] sum,
    output logic [2*ACC_W-1:0] hold
);
    logic [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [ACC_W-1:0]   ext_i, ext_q, sum_i, sum_q;
    logic [2*ACC_W-1:0] hold_q, hold_d;

    assign ext_i = {{(ACC_W-IN_W){sample[2*IN_W-1]}}, sample[2*IN_W-1:IN_W]};
    assign ext_q = {{(ACC_W-IN_W){sample[IN_W-1]}}, sample[IN_W-1:0]};
    assign sum_i = acc_i_q + ext_i;
    assign sum_q = acc_q_q + ext_q;
    assign sum   = {sum_i, sum_q};
    assign hold  = hold_q;

    always_comb begin
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        hold_d  = hold_q;
        if (clr || (acc_en && dump)) begin
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (acc_en) begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
        end
        if (load_hold) hold_d = sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            hold_q  <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            hold_q  <= hold_d;
        end
    end
endmodule

module ddc_daq_accum_serializer #(
    parameter int N_CH  = 4,
    parameter int IN_W  = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   dev_clk,
    input  logic                   dev_rst,
    input  logic [N_CH*2*IN_W-1:0] data_in,
    input  logic                   valid_in,
    input  logic                   resync,
    input  logic [CNT_W-1:0]       decim_len,
    output logic [2*ACC_W-1:0]     data_out,
    output logic [CH_W-1:0]        ch_out,
    output logic                   sof_out,
    output logic                   valid_out,
    output logic                   overrun,
    output logic [31:0]            frame_cnt
);
    typedef enum logic {WAIT_SYNC, RUN} acc_state_t;
    typedef enum logic {IDLE, SHIFT} ser_state_t;

    acc_state_t acc_state_q, acc_state_d;
    ser_state_t ser_state_q, ser_state_d;
    logic [CNT_W-1:0]   l_q, l_d, cnt_q, cnt_d;
    logic [CH_W-1:0]    idx_q, idx_d, ch_q, ch_d;
    logic [2*ACC_W-1:0] data_q, data_d;
    logic               sof_q, sof_d, valid_q, valid_d, overrun_q, overrun_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;

    logic [N_CH-1:0][2*ACC_W-1:0] sum_w, hold_w;
    logic [CNT_W-1:0] decim_eff;
    logic             run_valid, dump, busy, accept;

    assign decim_eff = (decim_len == '0) ? CNT_W'(1) : decim_len;
    assign run_valid = (acc_state_q == RUN) && valid_in && !resync;
    assign dump      = run_valid && (cnt_q == l_q - CNT_W'(1));
    assign busy      = (ser_state_q == SHIFT);
    assign accept    = dump && !busy;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
        ddc_daq_accum_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
            .clk      (dev_clk),
            .rst      (dev_rst),
            .clr      (resync),
            .acc_en   (run_valid),
            .dump     (dump),
            .load_hold(accept),
            .sample   (data_in[gi*2*IN_W +: 2*IN_W]),
            .sum      (sum_w[gi]),
            .hold     (hold_w[gi])
        );
    end

    // idx_q is 0 whenever the serialiser is IDLE, so channel 0 of a new frame is
    // taken straight from the live sum in the dump cycle; later beats come from hold.
    always_comb begin
        acc_state_d = acc_state_q;
        ser_state_d = ser_state_q;
        l_d         = l_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        ch_d        = ch_q;
        sof_d       = 1'b0;
        valid_d     = 1'b0;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        if (resync) begin
            acc_state_d = RUN;
            ser_state_d = IDLE;
            l_d         = decim_eff;
            cnt_d       = '0;
            idx_d       = '0;
            overrun_d   = 1'b0;
            frame_cnt_d = '0;
        end else begin
            if (run_valid) begin
                if (dump) begin
                    cnt_d = '0;
                    l_d   = decim_eff;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (dump && busy) overrun_d = 1'b1;
            if (accept) begin
                frame_cnt_d = frame_cnt_q + 32'd1;
                valid_d     = 1'b1;
                sof_d       = 1'b1;
                ch_d        = idx_q;
                data_d      = sum_w[idx_q];
                if (N_CH > 1) begin
                    ser_state_d = SHIFT;
                    idx_d       = CH_W'(1);
                end
            end else if (busy) begin
                valid_d = 1'b1;
                ch_d    = idx_q;
                data_d  = hold_w[idx_q];
                if (idx_q == CH_W'(N_CH-1)) begin
                    ser_state_d = IDLE;
                    idx_d       = '0;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
        end
    end

    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            acc_state_q <= WAIT_SYNC;
            ser_state_q <= IDLE;
            l_q         <= CNT_W'(1);
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            ch_q        <= '0;
            sof_q       <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            acc_state_q <= acc_state_d;
            ser_state_q <= ser_state_d;
            l_q         <= l_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
            sof_q       <= sof_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign data_out  = data_q;
    assign ch_out    = ch_q;
    assign sof_out   = sof_q;
    assign valid_out = valid_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_ddc_daq_accum_serializer.sv
// Scoreboard bench: a 4-lane instance with a frame-level reference model, plus a
// 1-lane instance for full-scale exactness and every-sample dumping.

module tb_ddc_daq_accum_serializer;
    localparam int N_CH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] data_in = '0;
    logic         valid_in = 1'b0, resync = 1'b0;
    logic [15:0]  decim_len = '0;
    logic [95:0]  data_out;
    logic [1:0]   ch_out;
    logic         sof_out, valid_out, overrun;
    logic [31:0]  frame_cnt;

    logic [31:0]  data_in1 = '0;
    logic         valid_in1 = 1'b0, resync1 = 1'b0;
    logic [15:0]  decim_len1 = '0;
    logic [95:0]  data_out1;
    logic [0:0]   ch_out1;
    logic         sof_out1, valid_out1, overrun1;
    logic [31:0]  frame_cnt1;

    always #5 clk = ~clk;

    ddc_daq_accum_serializer #(.N_CH(4)) dut (
        .dev_clk(clk), .dev_rst(rst), .data_in(data_in), .valid_in(valid_in),
        .resync(resync), .decim_len(decim_len), .data_out(data_out), .ch_out(ch_out),
        .sof_out(sof_out), .valid_out(valid_out), .overrun(overrun), .frame_cnt(frame_cnt));

    ddc_daq_accum_serializer #(.N_CH(1)) dut1 (
        .dev_clk(clk), .dev_rst(rst), .data_in(data_in1), .valid_in(valid_in1),
        .resync(resync1), .decim_len(decim_len1), .data_out(data_out1), .ch_out(ch_out1),
        .sof_out(sof_out1), .valid_out(valid_out1), .overrun(overrun1), .frame_cnt(frame_cnt1));

    typedef struct {
        int          edge_n;
        int          ch;
        logic        sof;
        logic [95:0] data;
    } beat_t;

    int n_tests = 0, n_fail = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // reference model state: sums per lane, sample count, frame window, serialiser free edge
    beat_t       expq[$], expq1[$];
    bit          m_run = 0, m1_run = 0;
    longint      m_i[N_CH], m_q[N_CH];
    longint      m1_i, m1_q;
    int          m_cnt, m_len, m_free, m1_cnt, m1_len;
    bit          m_ovr = 0, m1_ovr = 0;
    int unsigned m_frame = 0, m1_frame = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int eff_len(input logic [15:0] dl);
        return (dl == 0) ? 1 : int'(dl);
    endfunction

    task automatic model0(input int e, input bit v, input bit rs, input logic [127:0] d,
                          input logic [15:0] dl);
        beat_t b;
        if (rs) begin
            m_run = 1; m_cnt = 0; m_len = eff_len(dl); m_ovr = 0; m_frame = 0; m_free = e;
            for (int k = 0; k < N_CH; k++) begin m_i[k] = 0; m_q[k] = 0; end
            while (expq.size() > 0 && expq[$].edge_n >= e) void'(expq.pop_back());
        end else if (m_run && v) begin
            for (int k = 0; k < N_CH; k++) begin
                m_i[k] += longint'($signed(d[k*32+16 +: 16]));
                m_q[k] += longint'($signed(d[k*32 +: 16]));
            end
            m_cnt++;
            if (m_cnt == m_len) begin
                if (e >= m_free) begin
                    for (int k = 0; k < N_CH; k++) begin
                        b.edge_n = e + k; b.ch = k; b.sof = (k == 0);
                        b.data = {m_i[k][47:0], m_q[k][47:0]};
                        expq.push_back(b);
                    end
                    m_frame++;
                    m_free = e + N_CH;
                end else begin
                    m_ovr = 1;
                end
                for (int k = 0; k < N_CH; k++) begin m_i[k] = 0; m_q[k] = 0; end
                m_cnt = 0;
                m_len = eff_len(dl);
            end
        end
    endtask

    task automatic model1(input int e, input bit v, input bit rs, input logic [31:0] d,
                          input logic [15:0] dl);
        beat_t b;
        if (rs) begin
            m1_run = 1; m1_cnt = 0; m1_len = eff_len(dl); m1_ovr = 0; m1_frame = 0;
            m1_i = 0; m1_q = 0;
            while (expq1.size() > 0 && expq1[$].edge_n >= e) void'(expq1.pop_back());
        end else if (m1_run && v) begin
            m1_i += longint'($signed(d[31:16]));
            m1_q += longint'($signed(d[15:0]));
            m1_cnt++;
            if (m1_cnt == m1_len) begin
                b.edge_n = e; b.ch = 0; b.sof = 1'b1; b.data = {m1_i[47:0], m1_q[47:0]};
                expq1.push_back(b);
                m1_frame++;
                m1_i = 0; m1_q = 0; m1_cnt = 0; m1_len = eff_len(dl);
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1; valid_in = 0; resync = 0; valid_in1 = 0; resync1 = 0;
            m_run = 0; m_ovr = 0; m_frame = 0; m1_run = 0; m1_ovr = 0; m1_frame = 0;
            while (expq.size() > 0 && expq[$].edge_n >= edge_cnt + 1) void'(expq.pop_back());
            while (expq1.size() > 0 && expq1[$].edge_n >= edge_cnt + 1) void'(expq1.pop_back());
        end
    endtask

    task automatic step(input bit v, input bit rs, input logic [127:0] d, input logic [15:0] dl);
        @(negedge clk);
        rst = 0; valid_in = v; resync = rs; data_in = d; decim_len = dl;
        valid_in1 = 0; resync1 = 0;
        model0(edge_cnt + 1, v, rs, d, dl);
    endtask

    task automatic step1(input bit v, input bit rs, input logic [31:0] d, input logic [15:0] dl);
        @(negedge clk);
        rst = 0; valid_in1 = v; resync1 = rs; data_in1 = d; decim_len1 = dl;
        valid_in = 0; resync = 0;
        model1(edge_cnt + 1, v, rs, d, dl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, decim_len);
    endtask

    task automatic chk_status(input string nm);
        @(negedge clk);
        chk({nm, "_overrun"}, overrun, m_ovr);
        chk({nm, "_frame_cnt"}, frame_cnt, m_frame);
    endtask

    function automatic logic [127:0] case1_pat();
        logic [127:0] d;
        for (int k = 0; k < N_CH; k++) begin
            d[k*32+16 +: 16] = 16'(k + 1);
            d[k*32 +: 16]    = 16'(-(k + 1));
        end
        return d;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // monitors: pop the expected beat for this edge whenever one is due or valid_out rises
    beat_t b0, b1;
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].edge_n < edge_cnt) begin
            n_tests++; n_fail++;
            $display("FAIL beat_missing: ch %0d due at edge %0d", expq[0].ch, expq[0].edge_n);
            void'(expq.pop_front());
        end
        if (expq.size() > 0 && expq[0].edge_n == edge_cnt) begin
            b0 = expq.pop_front();
            chk("valid_out", valid_out, 1'b1);
            if (valid_out === 1'b1) begin
                chk("ch_out", ch_out, b0.ch);
                chk("sof_out", sof_out, b0.sof);
                chk("data_out", data_out, b0.data);
            end
        end else if (valid_out !== 1'b0 && !rst) begin
            chk("spurious_valid_out", valid_out, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (expq1.size() > 0 && expq1[0].edge_n == edge_cnt) begin
            b1 = expq1.pop_front();
            chk("valid_out1", valid_out1, 1'b1);
            if (valid_out1 === 1'b1) begin
                chk("ch_out1", ch_out1, b1.ch);
                chk("sof_out1", sof_out1, b1.sof);
                chk("data_out1", data_out1, b1.data);
            end
        end else if (valid_out1 !== 1'b0 && !rst) begin
            chk("spurious_valid_out1", valid_out1, 1'b0);
        end
    end

    initial begin
        logic [127:0] one_pat;
        logic [15:0]  dl;

        // reset state
        do_reset(3);
        @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_ch_out", ch_out, 0);
        chk("rst_sof_out", sof_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_valid_out1", valid_out1, 0);
        chk("rst_frame_cnt1", frame_cnt1, 0);

        // valid_in before any resync is ignored
        for (int i = 0; i < 12; i++) step(i[0], 0, rnd128(), 16'd2);
        idle(4);

        // basic frame: decim 8, I=k+1, Q=-(k+1)
        step(0, 1, '0, 16'd8);
        for (int i = 0; i < 8; i++) step(1, 0, case1_pat(), 16'd8);
        idle(6);
        chk_status("case1");

        // overrun: decim 2 at full rate, then resync clears status
        step(0, 1, '0, 16'd2);
        for (int i = 0; i < 12; i++) step(1, 0, rnd128(), 16'd2);
        idle(6);
        chk_status("overrun");
        step(0, 1, '0, 16'd2);
        chk_status("overrun_cleared");

        // resync after a partial integration discards it
        step(0, 1, '0, 16'd8);
        for (int i = 0; i < 5; i++) step(1, 0, rnd128(), 16'd8);
        step(1, 1, rnd128(), 16'd8);
        for (int k = 0; k < N_CH; k++) one_pat[k*32 +: 32] = {16'd1, 16'd1};
        for (int i = 0; i < 8; i++) step(1, 0, one_pat, 16'd8);
        idle(6);

        // gapped valid gives identical sums
        step(0, 1, '0, 16'd8);
        for (int i = 0; i < 24; i++) step(i % 3 == 0, 0, case1_pat(), 16'd8);
        idle(6);
        chk_status("gapped");

        // randomized traffic with occasional decim changes and resyncs
        dl = 16'($urandom_range(0, 6));
        step(0, 1, '0, dl);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) dl = 16'($urandom_range(0, 6));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, rnd128(), dl);
        end
        chk_status("random");

        // reset mid-frame, then valid before resync is ignored again
        step(0, 1, '0, 16'd4);
        for (int i = 0; i < 5; i++) step(1, 0, rnd128(), 16'd4);
        do_reset(2);
        @(negedge clk);
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        for (int i = 0; i < 6; i++) step(1, 0, rnd128(), 16'd4);
        step(0, 1, '0, 16'd4);
        for (int i = 0; i < 8; i++) step(1, 0, rnd128(), 16'd4);
        idle(6);
        chk_status("after_midrst");

        // single-lane full-scale exactness, then dump on every sample
        step1(0, 1, '0, 16'd65535);
        for (int i = 0; i < 65535; i++) step1(1, 0, {16'h8000, 16'h7fff}, 16'd65535);
        step1(0, 0, '0, 16'd0);
        step1(0, 1, '0, 16'd0);
        for (int i = 0; i < 6; i++) step1(1, 0, $urandom, 16'd0);
        step1(0, 0, '0, 16'd0);
        @(negedge clk);
        chk("n1_overrun", overrun1, m1_ovr);
        chk("n1_frame_cnt", frame_cnt1, m1_frame);

        idle(4);
        chk("drained", expq.size(), 0);
        chk("drained1", expq1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
